// File: rtl/n101_perips_pkg.sv
// Shared definitions for the perips register cells: write-mode encodings,
// byte-lane geometry and a helper for deriving strobe width.
package n101_perips_pkg;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        WR_WRITE  = 2'b00,
        WR_SET    = 2'b01,
        WR_CLEAR  = 2'b10,
        WR_TOGGLE = 2'b11
    } wr_mode_e;

    // Number of byte lanes needed to cover a register of width w.
    function automatic int strb_width(input int w);
        return (w + LANE_W - 1) / LANE_W;
    endfunction

endpackage

// File: rtl/n101_reg_wmode_lane.sv
// One byte lane of the write-mode datapath. Purely combinational: given the
// current lane value and the write operand, produce the lane's next value.
// LW may be less than 8 for the partial top lane of a narrow register.
module n101_reg_wmode_lane
    import n101_perips_pkg::*;
#(
    parameter int LW = 8
) (
    input  wr_mode_e        i_mode,
    input  logic            i_strb,
    input  logic [LW-1:0]   i_q,
    input  logic [LW-1:0]   i_d,
    output logic [LW-1:0]   o_next
);

    // Apply the selected read-modify-write operation when the lane is enabled.
    always_comb begin
        o_next = i_q;
        if (i_strb) begin
            case (i_mode)
                WR_WRITE:  o_next = i_d;
                WR_SET:    o_next = i_q | i_d;
                WR_CLEAR:  o_next = i_q & ~i_d;
                WR_TOGGLE: o_next = i_q ^ i_d;
                default:   o_next = i_q;
            endcase
        end
    end

endmodule

// File: rtl/n101_async_reset_reg_vec_shadow.sv
// Software/hardware register with optional shadow (double-buffered) stage.
// Software writes go to the shadow and are copied to the active value on
// commit; a hardware update overrides everything and loads both copies.
// With SHADOW_EN=0 the shadow collapses onto the active register.
module n101_async_reset_reg_vec_shadow
    import n101_perips_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              SHADOW_EN = 1'b1,
    localparam int             STRB_W    = strb_width(WIDTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_wr_en,
    input  logic [1:0]        io_wr_mode,
    input  logic [WIDTH-1:0]  io_wr_data,
    input  logic [STRB_W-1:0] io_wr_strb,
    input  logic              io_hw_en,
    input  logic [WIDTH-1:0]  io_hw_data,
    input  logic              io_commit,
    output logic [WIDTH-1:0]  io_q,
    output logic [WIDTH-1:0]  io_shadow_q,
    output logic              io_pending,
    output logic              io_changed
);

    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;
    logic             r_changed;

    wr_mode_e         w_mode;
    logic [WIDTH-1:0] w_op_q;
    logic [WIDTH-1:0] w_wr_result;
    logic [WIDTH-1:0] w_active_next;
    logic [WIDTH-1:0] w_shadow_next;
    logic             w_pending_next;
    logic             w_changed_next;

    assign w_mode = wr_mode_e'(io_wr_mode);

    // Software writes modify the shadow when buffering, else the active copy.
    assign w_op_q = SHADOW_EN ? r_shadow : r_active;

    // Per-lane write datapath; the top lane is trimmed to the bits that exist.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        localparam int LO = gi * LANE_W;
        localparam int LW = ((WIDTH - LO) >= LANE_W) ? LANE_W : (WIDTH - LO);

        n101_reg_wmode_lane #(
            .LW (LW)
        ) u_lane (
            .i_mode (w_mode),
            .i_strb (io_wr_strb[gi]),
            .i_q    (w_op_q[LO +: LW]),
            .i_d    (io_wr_data[LO +: LW]),
            .o_next (w_wr_result[LO +: LW])
        );
    end

    // Next-state selection: hardware update wins, then write, then commit.
    // Commit takes the shadow's post-write value so write+commit lands at once.
    always_comb begin
        w_active_next  = r_active;
        w_shadow_next  = r_shadow;
        w_pending_next = r_pending;
        if (SHADOW_EN) begin
            if (io_hw_en) begin
                w_active_next  = io_hw_data;
                w_shadow_next  = io_hw_data;
                w_pending_next = 1'b0;
            end else begin
                if (io_wr_en) begin
                    w_shadow_next = w_wr_result;
                end
                if (io_commit) begin
                    w_active_next  = w_shadow_next;
                    w_pending_next = 1'b0;
                end else if (io_wr_en) begin
                    w_pending_next = 1'b1;
                end
            end
        end else begin
            w_pending_next = 1'b0;
            if (io_hw_en) begin
                w_active_next = io_hw_data;
            end else if (io_wr_en) begin
                w_active_next = w_wr_result;
            end
            w_shadow_next = w_active_next;
        end
    end

    // Pulse only when the active value actually moves; reset release keeps
    // r_active at RESET_VAL, so it cannot generate a pulse.
    assign w_changed_next = (w_active_next != r_active);

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_active  <= RESET_VAL;
            r_shadow  <= RESET_VAL;
            r_pending <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_active  <= w_active_next;
            r_shadow  <= w_shadow_next;
            r_pending <= w_pending_next;
            r_changed <= w_changed_next;
        end
    end

    assign io_q        = r_active;
    assign io_shadow_q = SHADOW_EN ? r_shadow : r_active;
    assign io_pending  = r_pending;
    assign io_changed  = r_changed;

endmodule
